// File: rtl/chicken_track_tracker.sv
// Chicken Cha-Cha-Cha position and tail-feather tracker.
// Keeps every chicken's tile on a circular track and sequences turns.
// Resolves jump-over scans and tail steals, and declares the winner.
module chicken_track_tracker #(
    parameter int MAX_P     = 4,
    parameter int TRACK_LEN = 24,
    parameter int PW        = $clog2(TRACK_LEN),
    parameter int IW        = $clog2(MAX_P),
    parameter int TW        = $clog2(MAX_P + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          n_players,
    input  logic                advance,
    input  logic                miss,
    output logic [MAX_P*PW-1:0] pos_bus,
    output logic [MAX_P*TW-1:0] tails_bus,
    output logic [IW-1:0]       turn,
    output logic                busy,
    output logic                steal,
    output logic [IW-1:0]       victim,
    output logic                done,
    output logic [IW-1:0]       winner
);

    typedef enum logic [1:0] {IDLE, JUMP, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pos   [MAX_P];
    logic [TW-1:0] tails [MAX_P];
    logic [TW-1:0] n_eff;
    logic [TW-1:0] n_req;
    logic [PW-1:0] cand;
    logic [PW-1:0] probe;
    logic          hit;
    logic [IW-1:0] occupant;
    logic [TW-1:0] sum_tails;

    // Start tile of player idx when cnt players are seated; evenly spread round the ring.
    // Each k branch divides by a constant, so no runtime divider is built.
    function automatic logic [PW-1:0] start_tile(input int idx, input logic [TW-1:0] cnt);
        logic [PW-1:0] t;
        t = '0;
        for (int k = 2; k <= MAX_P; k++) begin
            if (int'(cnt) == k && idx < k) begin
                t = PW'((idx * TRACK_LEN) / k);
            end
        end
        return t;
    endfunction

    // Next tile clockwise, wrapping back to tile 0 at the end of the ring.
    function automatic logic [PW-1:0] next_tile(input logic [PW-1:0] p);
        return (int'(p) == TRACK_LEN - 1) ? '0 : p + PW'(1);
    endfunction

    // Clamp the requested player count to the legal 2..MAX_P range.
    always_comb begin
        if (int'(n_players) < 2) begin
            n_req = TW'(2);
        end else if (int'(n_players) > MAX_P) begin
            n_req = TW'(MAX_P);
        end else begin
            n_req = TW'(n_players);
        end
    end

    // Probe one tile for another active chicken: the destination while idle, the scan candidate while jumping.
    always_comb begin
        probe    = (state == JUMP) ? cand : next_tile(pos[turn]);
        hit      = 1'b0;
        occupant = '0;
        for (int i = 0; i < MAX_P; i++) begin
            if (i < int'(n_eff) && IW'(i) != turn && pos[i] == probe) begin
                hit      = 1'b1;
                occupant = IW'(i);
            end
        end
    end

    assign sum_tails = tails[turn] + tails[victim];
    assign busy      = (state == JUMP);
    assign done      = (state == DONE);

    // Flatten the per-player registers onto the display buses.
    for (genvar g = 0; g < MAX_P; g++) begin : g_pack
        assign pos_bus[g*PW +: PW]   = pos[g];
        assign tails_bus[g*TW +: TW] = tails[g];
    end

    // Game FSM: moves, turn passing, the one-tile-per-cycle jump scan and the steal.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_eff  <= n_req;
            state  <= IDLE;
            turn   <= '0;
            cand   <= '0;
            victim <= '0;
            winner <= '0;
            steal  <= 1'b0;
            for (int i = 0; i < MAX_P; i++) begin
                pos[i]   <= start_tile(i, n_req);
                tails[i] <= (i < int'(n_req)) ? TW'(1) : '0;
            end
        end else begin
            steal <= 1'b0;
            case (state)
                IDLE: begin
                    if (advance) begin
                        if (!hit) begin
                            pos[turn] <= probe;
                        end else begin
                            victim <= occupant;
                            cand   <= next_tile(probe);
                            state  <= JUMP;
                        end
                    end else if (miss) begin
                        turn <= (turn == IW'(n_eff - TW'(1))) ? '0 : turn + IW'(1);
                    end
                end
                JUMP: begin
                    if (hit) begin
                        cand <= next_tile(cand);
                    end else begin
                        pos[turn]     <= cand;
                        tails[turn]   <= sum_tails;
                        tails[victim] <= '0;
                        steal         <= 1'b1;
                        if (sum_tails == n_eff) begin
                            winner <= turn;
                            state  <= DONE;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chicken_track_tracker.sv
// Directed self-checking bench for chicken_track_tracker.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_chicken_track_tracker;

    localparam int MAX_P     = 4;
    localparam int TRACK_LEN = 24;
    localparam int PW        = $clog2(TRACK_LEN);
    localparam int IW        = $clog2(MAX_P);
    localparam int TW        = $clog2(MAX_P + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [3:0]          n_players = 4'd4;
    logic                advance = 1'b0;
    logic                miss = 1'b0;
    logic [MAX_P*PW-1:0] pos_bus;
    logic [MAX_P*TW-1:0] tails_bus;
    logic [IW-1:0]       turn;
    logic                busy;
    logic                steal;
    logic [IW-1:0]       victim;
    logic                done;
    logic [IW-1:0]       winner;

    int   passCount  = 0;
    int   checkCount = 0;
    logic sawBusy;

    chicken_track_tracker #(
        .MAX_P(MAX_P),
        .TRACK_LEN(TRACK_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .n_players(n_players),
        .advance(advance),
        .miss(miss),
        .pos_bus(pos_bus),
        .tails_bus(tails_bus),
        .turn(turn),
        .busy(busy),
        .steal(steal),
        .victim(victim),
        .done(done),
        .winner(winner)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] posOf(input int i);
        return 32'(pos_bus[i*PW +: PW]);
    endfunction

    function automatic logic [31:0] tailsOf(input int i);
        return 32'(tails_bus[i*TW +: TW]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Drive one cycle of advance/miss, returning at the falling edge after it was sampled.
    task automatic applyStimulus(input logic a, input logic m);
        @(negedge clk);
        advance = a;
        miss    = m;
        @(negedge clk);
        advance = 1'b0;
        miss    = 1'b0;
    endtask

    task automatic resetDut(input logic [3:0] n);
        @(negedge clk);
        rst       = 1'b1;
        n_players = n;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkStart4(input string tag);
        checkOutput({tag, "_pos"}, 32'(pos_bus), 32'({5'd18, 5'd12, 5'd6, 5'd0}));
        checkOutput({tag, "_tails"}, 32'(tails_bus), 32'({3'd1, 3'd1, 3'd1, 3'd1}));
    endtask

    // Directed scenario sequence.
    initial begin
        // Reset and clamp.
        resetDut(4'd4);
        checkStart4("rst4");
        checkOutput("rst4_turn", 32'(turn), 0);
        checkOutput("rst4_busy", 32'(busy), 0);
        checkOutput("rst4_done", 32'(done), 0);
        checkOutput("rst4_steal", 32'(steal), 0);
        resetDut(4'd7);
        checkStart4("rst7");
        resetDut(4'd1);
        checkOutput("rst1_pos", 32'(pos_bus), 32'({5'd0, 5'd0, 5'd12, 5'd0}));
        checkOutput("rst1_tails", 32'(tails_bus), 32'({3'd0, 3'd0, 3'd1, 3'd1}));

        // Simple moves then a single-hop steal.
        resetDut(4'd4);
        sawBusy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 1'b0);
            sawBusy = sawBusy | busy;
        end
        checkOutput("move_pos0", posOf(0), 5);
        checkOutput("move_nobusy", 32'(sawBusy), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("steal1_busy", 32'(busy), 1);
        checkOutput("steal1_pos0_hold", posOf(0), 5);
        @(negedge clk);
        checkOutput("steal1_busy_end", 32'(busy), 0);
        checkOutput("steal1_pulse", 32'(steal), 1);
        checkOutput("steal1_pos0", posOf(0), 7);
        checkOutput("steal1_victim", 32'(victim), 1);
        checkOutput("steal1_tails0", tailsOf(0), 2);
        checkOutput("steal1_tails1", tailsOf(1), 0);
        checkOutput("steal1_turn", 32'(turn), 0);
        @(negedge clk);
        checkOutput("steal1_pulse_end", 32'(steal), 0);

        // Chained jump over two occupied tiles.
        resetDut(4'd4);
        applyStimulus(1'b0, 1'b1);
        checkOutput("chain_turn1", 32'(turn), 1);
        for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b0);
        checkOutput("chain_pos1", posOf(1), 11);
        for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b1);
        checkOutput("chain_turn0", 32'(turn), 0);
        for (int s = 0; s < 10; s++) applyStimulus(1'b1, 1'b0);
        checkOutput("chain_pos0", posOf(0), 10);
        applyStimulus(1'b1, 1'b0);
        checkOutput("chain_busy_a", 32'(busy), 1);
        @(negedge clk);
        checkOutput("chain_busy_b", 32'(busy), 1);
        checkOutput("chain_nosteal_yet", 32'(steal), 0);
        @(negedge clk);
        checkOutput("chain_busy_end", 32'(busy), 0);
        checkOutput("chain_pulse", 32'(steal), 1);
        checkOutput("chain_pos0_final", posOf(0), 13);
        checkOutput("chain_victim", 32'(victim), 1);
        checkOutput("chain_tails0", tailsOf(0), 2);
        checkOutput("chain_tails2", tailsOf(2), 1);

        // Wrap round the ring and win with two players.
        resetDut(4'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("win_turn1", 32'(turn), 1);
        for (int s = 0; s < 11; s++) applyStimulus(1'b1, 1'b0);
        checkOutput("win_pos1_23", posOf(1), 23);
        applyStimulus(1'b1, 1'b0);
        checkOutput("win_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("win_pos1", posOf(1), 1);
        checkOutput("win_tails1", tailsOf(1), 2);
        checkOutput("win_tails0", tailsOf(0), 0);
        checkOutput("win_victim", 32'(victim), 0);
        checkOutput("win_pulse", 32'(steal), 1);
        checkOutput("win_done", 32'(done), 1);
        checkOutput("win_winner", 32'(winner), 1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("frozen_pos", 32'(pos_bus), 32'({5'd0, 5'd0, 5'd1, 5'd0}));
        checkOutput("frozen_turn", 32'(turn), 1);
        checkOutput("frozen_done", 32'(done), 1);
        checkOutput("frozen_steal", 32'(steal), 0);

        // Simultaneous advance/miss, and miss ignored during a jump.
        resetDut(4'd3);
        checkOutput("rst3_pos", 32'(pos_bus), 32'({5'd0, 5'd16, 5'd8, 5'd0}));
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_pos0", posOf(0), 1);
        checkOutput("both_turn", 32'(turn), 0);
        for (int s = 0; s < 6; s++) applyStimulus(1'b1, 1'b0);
        checkOutput("busy_setup_pos0", posOf(0), 7);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_miss_busy", 32'(busy), 1);
        miss = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        checkOutput("busy_miss_pulse", 32'(steal), 1);
        checkOutput("busy_miss_pos0", posOf(0), 9);
        checkOutput("busy_miss_turn", 32'(turn), 0);
        @(negedge clk);
        checkOutput("busy_miss_turn_after", 32'(turn), 0);

        // Reset in the middle of a jump scan.
        resetDut(4'd4);
        for (int s = 0; s < 6; s++) applyStimulus(1'b1, 1'b0);
        checkOutput("midjump_busy", 32'(busy), 1);
        rst       = 1'b1;
        n_players = 4'd4;
        @(negedge clk);
        rst = 1'b0;
        checkStart4("midjump_rst");
        checkOutput("midjump_busy_clr", 32'(busy), 0);
        checkOutput("midjump_steal", 32'(steal), 0);
        @(negedge clk);
        checkOutput("midjump_steal_after", 32'(steal), 0);
        checkOutput("midjump_pos0_after", posOf(0), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/chicken_track_tracker.md
# chicken_track_tracker

Parametrised multi-player position and tail-feather tracker for the Chicken Cha-Cha-Cha board. It holds every chicken's tile on a circular track of TRACK_LEN tiles, seats 2..MAX_P players at evenly spread start tiles, and sequences whose turn it is. It resolves jumps and steals when a chicken lands on an occupied tile, and declares the winner. It sits between the card-match/guess logic, which drives `advance`/`miss`, and the display/LED drivers, which consume the position and tail buses.

## Interface
- MAX_P, 4, maximum player count (≥2)
- TRACK_LEN, 24, tiles on the ring (> MAX_P)
- PW, $clog2(TRACK_LEN), position width
- IW, $clog2(MAX_P), player-index width
- TW, $clog2(MAX_P+1), tail-count width
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- n_players  in  4  requested player count; sampled only while rst=1
- advance  in  1  one-cycle pulse: current player guessed right, move one tile
- miss  in  1  one-cycle pulse: current player guessed wrong, pass turn
- pos_bus  out  MAX_P*PW  tile of player i at bits [i*PW +: PW]
- tails_bus  out  MAX_P*TW  tails held by player i at [i*TW +: TW]
- turn  out  IW  index of the player to move
- busy  out  1  high while a jump scan is in progress
- steal  out  1  one-cycle pulse when a steal completes
- victim  out  IW  player robbed; valid with steal, held until next steal
- done  out  1  game over; held until rst
- winner  out  IW  winning player; valid while done=1

## Operation
- Effective count n = clamp(n_players, 2, MAX_P), latched while rst=1.
- Reset values:
  - pos[i] = floor(i*TRACK_LEN/n) for i<n; pos[i] = 0 for i≥n.
  - tails[i] = 1 for i<n; tails[i] = 0 for i≥n.
  - turn = 0; busy, steal, done = 0; victim, winner = 0; state IDLE.
  - With n=4, L=24 the start tiles are 0/6/12/18. With n=3 they are 0/8/16. With n=2 they are 0/12.
- Invariant: active players always occupy distinct tiles. Inactive players never move or match.
- All position arithmetic is modulo TRACK_LEN: (p+1 == TRACK_LEN) → 0.
- FSM states are IDLE, JUMP and DONE.
- IDLE, advance=1:
  - Compute dest = pos[turn]+1.
  - If no other active player is on dest: pos[turn] ← dest and turn is unchanged.
  - Otherwise: victim ← occupant of dest, cand ← dest+1, go to JUMP.
- IDLE, miss=1 (advance=0): turn ← (turn+1) mod n.
- advance and miss asserted together: advance wins, miss is dropped.
- JUMP (busy=1), one candidate tile checked per cycle:
  - If cand is occupied by another active player, cand ← cand+1 and stay in JUMP. No further steals are taken.
  - If cand is free:
    - pos[turn] ← cand.
    - tails[turn] ← tails[turn] + tails[victim]; tails[victim] ← 0.
    - steal pulses for one cycle.
    - If the new tails[turn] == n: done ← 1, winner ← turn, go to DONE. Otherwise go to IDLE.
  - A free tile always exists because n < TRACK_LEN, so JUMP lasts at most n-1 cycles.
- A robbed player with 0 tails still moves, takes turns, blocks tiles and can be robbed again; a steal of 0 tails is legal.
- advance/miss are ignored while busy=1 or in DONE.
- DONE: all state is frozen until rst.

## Timing
- Simple move: outputs update on the first posedge after the advance edge (latency 1).
- Steal with k occupied candidates: pos, tails and the steal pulse appear k+2 cycles after the advance edge. busy is high for k+1 cycles, starting the cycle after advance.
- done rises in the same cycle as the winning steal pulse.
- rst asserted in any state, including mid-JUMP, restores all reset values on the next posedge. Any scan in progress is discarded.
- All outputs are registered; none is combinational from inputs.

## Test plan
- Reset and clamp: rst with n_players=4 → pos 0/6/12/18, tails 1/1/1/1, turn 0. rst with n_players=7 → same as 4. rst with n_players=1 → pos 0/12, tails 1/1/0/0.
- Simple move and steal (n=4):
  - 5×advance → pos0=5, busy never set.
  - 6th advance → busy 1 cycle, then pos0=7, steal pulse, victim=1, tails0=2, tails1=0.
- Chained jump (n=4):
  - miss, then 5×advance → pos1=11. Then 3×miss → turn=0.
  - 10×advance → pos0=10.
  - Next advance → busy 2 cycles (tile 12 held by p2), pos0=13, victim=1, tails2 unchanged.
- Wrap and win (n=2):
  - miss → turn=1. 11×advance → pos1=23.
  - advance → dest 0 occupied → pos1=1, tails1=2, done=1, winner=1.
  - Further advance/miss → no change.
- Simultaneous and busy inputs (n=3):
  - advance+miss in the same cycle → pos0=1, turn stays 0.
  - During a JUMP, pulse miss → turn unchanged after the steal.
- Reset mid-JUMP (n=4): set up the 6th-advance steal, assert rst the cycle busy=1 → next cycle pos 0/6/12/18, tails 1/1/1/1, busy=0, no steal pulse.
